// File: rtl/reg_status.sv
// Register-status (rename-tag) table: one busy bit and one producing ROB tag per
// architectural register, updated by issue/commit and cleared by a mispredict flush.
module reg_status #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    input  logic                 query_valid,
    input  logic [4:0]           query_rs1,
    input  logic [4:0]           query_rs2,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_rd,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    output logic                 rs1_busy,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs2_tag,
    output logic                 query_done,
    output logic [5:0]           busy_cnt
);

    logic [31:0]                busy_q, busy_d;
    logic [31:0][ROB_WIDTH-1:0] tag_q, tag_d;
    logic                       rs1_busy_q, rs1_busy_d;
    logic [ROB_WIDTH-1:0]       rs1_tag_q, rs1_tag_d;
    logic                       rs2_busy_q, rs2_busy_d;
    logic [ROB_WIDTH-1:0]       rs2_tag_q, rs2_tag_d;
    logic                       query_done_q, query_done_d;
    logic [5:0]                 busy_cnt_q, busy_cnt_d;

    logic        commit_hit;
    logic        issue_act;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] busy_after_commit;

    always_comb begin
        commit_hit = commit_valid && (commit_rd != 5'd0) && busy_q[commit_rd]
                     && (tag_q[commit_rd] == commit_tag);
        issue_act  = issue_valid && (issue_rd != 5'd0);

        busy_after_commit = busy_q;
        if (commit_hit) begin
            busy_after_commit[commit_rd] = 1'b0;
        end

        // Count moves on pre-edge occupancy: re-issuing a busy rd or an
        // issue racing a commit on the same rd leaves the total unchanged.
        cnt_inc = issue_act && !busy_q[issue_rd];
        cnt_dec = commit_hit && !(issue_act && (issue_rd == commit_rd));
    end

    always_comb begin
        busy_d       = busy_q;
        tag_d        = tag_q;
        rs1_busy_d   = rs1_busy_q;
        rs1_tag_d    = rs1_tag_q;
        rs2_busy_d   = rs2_busy_q;
        rs2_tag_d    = rs2_tag_q;
        query_done_d = query_done_q;
        busy_cnt_d   = busy_cnt_q;

        if (rdy_in) begin
            if (flush) begin
                busy_d       = '0;
                rs1_busy_d   = 1'b0;
                rs1_tag_d    = '0;
                rs2_busy_d   = 1'b0;
                rs2_tag_d    = '0;
                query_done_d = 1'b0;
                busy_cnt_d   = '0;
            end else begin
                // Lookups see this cycle's commit but never this cycle's issue.
                query_done_d = query_valid;
                rs1_busy_d   = 1'b0;
                rs1_tag_d    = '0;
                rs2_busy_d   = 1'b0;
                rs2_tag_d    = '0;
                if (query_valid) begin
                    if ((query_rs1 != 5'd0) && busy_after_commit[query_rs1]) begin
                        rs1_busy_d = 1'b1;
                        rs1_tag_d  = tag_q[query_rs1];
                    end
                    if ((query_rs2 != 5'd0) && busy_after_commit[query_rs2]) begin
                        rs2_busy_d = 1'b1;
                        rs2_tag_d  = tag_q[query_rs2];
                    end
                end

                busy_d = busy_after_commit;
                if (issue_act) begin
                    busy_d[issue_rd] = 1'b1;
                    tag_d[issue_rd]  = issue_tag;
                end

                busy_cnt_d = busy_cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q       <= '0;
            tag_q        <= '0;
            rs1_busy_q   <= 1'b0;
            rs1_tag_q    <= '0;
            rs2_busy_q   <= 1'b0;
            rs2_tag_q    <= '0;
            query_done_q <= 1'b0;
            busy_cnt_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            tag_q        <= tag_d;
            rs1_busy_q   <= rs1_busy_d;
            rs1_tag_q    <= rs1_tag_d;
            rs2_busy_q   <= rs2_busy_d;
            rs2_tag_q    <= rs2_tag_d;
            query_done_q <= query_done_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign rs1_busy   = rs1_busy_q;
    assign rs1_tag    = rs1_tag_q;
    assign rs2_busy   = rs2_busy_q;
    assign rs2_tag    = rs2_tag_q;
    assign query_done = query_done_q;
    assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_reg_status.sv
// Self-checking bench for reg_status: directed scenarios followed by random
// traffic, all compared against a sequential behavioural model of the table.
module tb_reg_status;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush;
    logic          issue_valid, query_valid, commit_valid;
    logic [4:0]    issue_rd, query_rs1, query_rs2, commit_rd;
    logic [RW-1:0] issue_tag, commit_tag;
    logic          rs1_busy, rs2_busy, query_done;
    logic [RW-1:0] rs1_tag, rs2_tag;
    logic [5:0]    busy_cnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model state and expected registered outputs
    bit      m_busy [32];
    int      m_tag  [32];
    bit      e_rs1_busy, e_rs2_busy, e_done;
    int      e_rs1_tag, e_rs2_tag;

    reg_status #(.ROB_WIDTH(RW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .query_valid(query_valid), .query_rs1(query_rs1), .query_rs2(query_rs2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .query_done(query_done), .busy_cnt(busy_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", name, observed, expected, $time);
        end
    endtask

    function automatic int modelCount();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Instruction-level semantics: reset > stall > flush > (commit, lookup, issue)
    task automatic modelStep(input bit rst, input bit rdy, input bit fl,
                             input bit iv, input int ird, input int itag,
                             input bit qv, input int q1, input int q2,
                             input bit cv, input int crd, input int ctag);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_busy[r] = 0;
                m_tag[r]  = 0;
            end
            e_rs1_busy = 0; e_rs2_busy = 0; e_done = 0; e_rs1_tag = 0; e_rs2_tag = 0;
        end else if (!rdy) begin
            return;
        end else if (fl) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            e_rs1_busy = 0; e_rs2_busy = 0; e_done = 0; e_rs1_tag = 0; e_rs2_tag = 0;
        end else begin
            if (cv && crd != 0 && m_busy[crd] && m_tag[crd] == ctag) m_busy[crd] = 0;
            e_done     = qv;
            e_rs1_busy = qv && q1 != 0 && m_busy[q1];
            e_rs2_busy = qv && q2 != 0 && m_busy[q2];
            e_rs1_tag  = e_rs1_busy ? m_tag[q1] : 0;
            e_rs2_tag  = e_rs2_busy ? m_tag[q2] : 0;
            if (iv && ird != 0) begin
                m_busy[ird] = 1;
                m_tag[ird]  = itag;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit rdy, input bit fl,
                                 input bit iv, input int ird, input int itag,
                                 input bit qv, input int q1, input int q2,
                                 input bit cv, input int crd, input int ctag);
        rst_in = rst; rdy_in = rdy; flush = fl;
        issue_valid = iv;  issue_rd = 5'(ird);  issue_tag = RW'(itag);
        query_valid = qv;  query_rs1 = 5'(q1);  query_rs2 = 5'(q2);
        commit_valid = cv; commit_rd = 5'(crd); commit_tag = RW'(ctag);
        modelStep(rst, rdy, fl, iv, ird, itag, qv, q1, q2, cv, crd, ctag);
        @(posedge clk_in);
        #1;
        checkOutput("query_done", int'(query_done), int'(e_done));
        checkOutput("rs1_busy",   int'(rs1_busy),   int'(e_rs1_busy));
        checkOutput("rs1_tag",    int'(rs1_tag),    e_rs1_tag);
        checkOutput("rs2_busy",   int'(rs2_busy),   int'(e_rs2_busy));
        checkOutput("rs2_tag",    int'(rs2_tag),    e_rs2_tag);
        checkOutput("busy_cnt",   int'(busy_cnt),   modelCount());
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic query(input int q1, input int q2);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, q1, q2, 0, 0, 0);
    endtask

    initial begin
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 4, 2, 1, 4, 4, 0, 0, 0);
        checkOutput("reset_cnt", int'(busy_cnt), 0);
        checkOutput("reset_done", int'(query_done), 0);

        query(5, 6);
        checkOutput("plan1_done", int'(query_done), 1);
        checkOutput("plan1_rs1", int'(rs1_busy), 0);
        checkOutput("plan1_rs2", int'(rs2_busy), 0);

        applyStimulus(0, 1, 0, 1, 5, 3, 0, 0, 0, 0, 0, 0);
        query(5, 0);
        checkOutput("plan2_busy", int'(rs1_busy), 1);
        checkOutput("plan2_tag", int'(rs1_tag), 3);
        checkOutput("plan2_cnt", int'(busy_cnt), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3);
        checkOutput("plan2_cnt_after", int'(busy_cnt), 0);
        query(5, 0);
        checkOutput("plan2_cleared", int'(rs1_busy), 0);

        applyStimulus(0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 7, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        checkOutput("plan3_stale_cnt", int'(busy_cnt), 1);
        query(7, 0);
        checkOutput("plan3_busy", int'(rs1_busy), 1);
        checkOutput("plan3_tag", int'(rs1_tag), 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 2);
        checkOutput("plan3_cnt", int'(busy_cnt), 0);

        applyStimulus(0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 9, 4, 1, 9, 0, 1, 9, 1);
        checkOutput("plan4_bypass", int'(rs1_busy), 0);
        checkOutput("plan4_cnt", int'(busy_cnt), 1);
        query(9, 0);
        checkOutput("plan4_busy", int'(rs1_busy), 1);
        checkOutput("plan4_tag", int'(rs1_tag), 4);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 4);

        applyStimulus(0, 1, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0);
        checkOutput("plan5_cnt", int'(busy_cnt), 0);
        checkOutput("plan5_rs2", int'(rs2_busy), 0);
        checkOutput("plan5_tag", int'(rs2_tag), 0);

        for (int r = 1; r <= 10; r++) applyStimulus(0, 1, 0, 1, r, r, 0, 0, 0, 0, 0, 0);
        checkOutput("plan6_cnt10", int'(busy_cnt), 10);
        applyStimulus(0, 1, 1, 1, 11, 5, 1, 1, 2, 0, 0, 0);
        checkOutput("plan6_flush_cnt", int'(busy_cnt), 0);
        for (int r = 1; r <= 11; r++) begin
            query(r, r);
            checkOutput("plan6_flushed", int'(rs1_busy), 0);
        end
        applyStimulus(0, 0, 0, 1, 3, 7, 1, 3, 3, 0, 0, 0);
        checkOutput("plan6_stall_cnt", int'(busy_cnt), 0);
        checkOutput("plan6_stall_done", int'(query_done), 1);
        query(3, 0);
        checkOutput("plan6_stall_busy", int'(rs1_busy), 0);

        // Random traffic over a narrow register range to force collisions
        for (int n = 0; n < 3000; n++) begin
            int ird, crd, ctag;
            bit cv;
            ird  = int'($urandom_range(0, 9));
            crd  = int'($urandom_range(0, 9));
            cv   = ($urandom_range(0, 1) == 1);
            ctag = ($urandom_range(0, 2) != 0) ? m_tag[crd] : int'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 1) == 1, ird, int'($urandom_range(0, 15)),
                          $urandom_range(0, 3) != 0, int'($urandom_range(0, 9)),
                          int'($urandom_range(0, 9)), cv, crd, ctag);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_status.md
Name: reg_status

Overview:
- Register-status (rename-tag) table that sits beside the architectural register file.
- Records, for every architectural register, whether an in-flight ROB entry will write it and which ROB tag that is.
- Dispatch queries it to decide whether an operand comes from the register file or waits on a ROB tag.
- Issue marks destinations busy, commit clears them, and a mispredict flush clears everything.

Parameters:
ROB_WIDTH, 4, width of a ROB tag (ROB depth = 2^ROB_WIDTH)

Ports:
clk_in  input  1  clock; all state updates on posedge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when 0, no state or output changes
flush  input  1  mispredict flush; clear all busy bits
issue_valid  input  1  an instruction with a destination is dispatched this cycle
issue_rd  input  5  destination register of the issuing instruction
issue_tag  input  ROB_WIDTH  ROB tag allocated to the issuing instruction
query_valid  input  1  operand lookup request
query_rs1  input  5  source register 1 to look up
query_rs2  input  5  source register 2 to look up
commit_valid  input  1  ROB commits an instruction with a destination this cycle
commit_rd  input  5  destination register being committed
commit_tag  input  ROB_WIDTH  ROB tag of the committing entry
rs1_busy  output  1  registered: rs1 awaits a ROB result
rs1_tag  output  ROB_WIDTH  registered: producing ROB tag for rs1 (0 when not busy)
rs2_busy  output  1  registered: rs2 awaits a ROB result
rs2_tag  output  ROB_WIDTH  registered: producing ROB tag for rs2 (0 when not busy)
query_done  output  1  registered: rs1/rs2 outputs are valid this cycle
busy_cnt  output  6  registered count of busy registers (0..31)

Behaviour:
- Storage: 32 busy bits and 32 ROB_WIDTH-bit tags.
  - Register x0 is never busy.
  - Issue or commit with rd=0 is ignored.
- Reset: while rst_in=1 at a posedge:
  - All busy bits cleared and all tags set to 0.
  - All outputs cleared to 0, including busy_cnt.
  - Reset takes priority over rdy_in.
- rdy_in=0: hold all state and outputs. Inputs presented that cycle are dropped.
- Priority within a cycle (rdy_in=1): reset > flush > {issue, commit}.
- Flush:
  - Next cycle: all busy bits 0, busy_cnt=0, query_done=0, rs*_busy=0, rs*_tag=0.
  - Tags need not be cleared.
  - Issue, commit and query in the flush cycle are discarded.
- Commit: if commit_valid, commit_rd≠0, busy[commit_rd]=1 and tag[commit_rd]==commit_tag, then clear busy[commit_rd]. A tag mismatch (register renamed by a younger instruction) leaves it unchanged.
- Issue: if issue_valid and issue_rd≠0, set busy[issue_rd]=1 and tag[issue_rd]=issue_tag.
- Issue and commit to the same rd in one cycle: issue wins. The register ends busy with issue_tag.
- Query latency: 1 cycle.
  - query_valid at edge N gives query_done=1 with results during cycle N+1.
  - Without query_valid, query_done=0 and rs*_busy/rs*_tag=0.
- Query view: uses pre-edge state with the same-cycle commit applied, and the same-cycle issue NOT applied.
  - An instruction never depends on its own rd.
  - A source that matches a same-cycle matching commit reports busy=0. The register-file write happens on the same edge.
  - rs=0 always returns busy=0, tag=0.
- busy_cnt:
  - +1 when issue sets a register that ends the cycle newly busy.
  - −1 when commit clears a register and no same-cycle issue targets that rd.
  - Issue to an already-busy rd: no change.
  - Issue and matching commit to the same rd: no change.
  - Issue and commit to different rds: net 0.
  - busy_cnt always equals the number of set busy bits.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then query x5,x6 -> next cycle query_done=1, rs1_busy=0, rs2_busy=0, busy_cnt=0.
- Issue rd=5 tag=3; next cycle query rs1=5 -> rs1_busy=1, rs1_tag=3, busy_cnt=1; commit rd=5 tag=3 -> busy_cnt=0, and a later query shows busy=0.
- Issue rd=7 tag=1, then rd=7 tag=2; commit rd=7 tag=1 -> x7 stays busy with tag 2, busy_cnt=1; commit tag=2 -> busy_cnt=0.
- Same cycle: commit rd=9 (matching tag) + query rs1=9 + issue rd=9 tag=4 -> rs1_busy=0 that query; the following query shows busy=1, tag=4; busy_cnt unchanged.
- Issue rd=0 and query rs2=0 -> busy_cnt=0, rs2_busy=0, rs2_tag=0.
- Mark x1..x10 busy (busy_cnt=10), then assert flush together with issue rd=11 -> busy_cnt=0, all queries not busy. Separately, with rdy_in=0 during an issue, no state change.
